// File: rtl/pipe_pkg.sv
// Shared types and encodings for the ID/EX pipeline register and its neighbours.
package pipe_pkg;

   localparam int ALUOP_W = 2;
   localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
   localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
   localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;

   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic               regwrite;
      logic               memtoreg;
      logic               memread;
      logic               memwrite;
      logic               branch;
      logic               alusrc;
      logic               regdst;
      logic [ALUOP_W-1:0] aluop;
   } ctrl_t;

   // A bubble is exactly this value: no writes, no memory access, no branch.
   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at MAX instead of wrapping.
// Latency 1 cycle, no backpressure (inc is sampled every edge).
module sat_counter #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] MAX   = '1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc && (count != MAX))
         count <= count + WIDTH'(1);
   end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with bubble insertion, stall/bubble statistics and a load-use stall watchdog.
// Latency 1 cycle; always advances, no backpressure (flushes turn the load into a bubble).
module id_ex_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int CNT_W       = 16,
   parameter int MAX_LWSTALL = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               id_flush_lwstall,
   input  logic               id_flush_branch,
   input  logic               id_valid,
   input  logic               id_regwrite,
   input  logic               id_memtoreg,
   input  logic               id_memread,
   input  logic               id_memwrite,
   input  logic               id_branch,
   input  logic               id_alusrc,
   input  logic               id_regdst,
   input  logic [1:0]         id_aluop,
   input  logic [DATA_W-1:0]  id_pc_plus4,
   input  logic [DATA_W-1:0]  id_read_data1,
   input  logic [DATA_W-1:0]  id_read_data2,
   input  logic [DATA_W-1:0]  id_sign_ext_imm,
   input  logic [4:0]         id_rs,
   input  logic [4:0]         id_rt,
   input  logic [4:0]         id_rd,
   output logic               id_ex_valid,
   output logic               id_ex_regwrite,
   output logic               id_ex_memtoreg,
   output logic               id_ex_memread,
   output logic               id_ex_memwrite,
   output logic               id_ex_branch,
   output logic               id_ex_alusrc,
   output logic               id_ex_regdst,
   output logic [1:0]         id_ex_aluop,
   output logic [DATA_W-1:0]  id_ex_pc_plus4,
   output logic [DATA_W-1:0]  id_ex_read_data1,
   output logic [DATA_W-1:0]  id_ex_read_data2,
   output logic [DATA_W-1:0]  id_ex_sign_ext_imm,
   output logic [4:0]         id_ex_rs,
   output logic [4:0]         id_ex_registerrt,
   output logic [4:0]         id_ex_rd,
   output logic [CNT_W-1:0]   lwstall_count,
   output logic [CNT_W-1:0]   bubble_count,
   output logic               lwstall_timeout
);

   localparam int RUN_W = $clog2(MAX_LWSTALL + 2);

   logic              bubble;
   ctrl_t             id_ctrl;
   ctrl_t             ex_ctrl;
   logic [RUN_W-1:0]  run_count;

   assign bubble = id_flush_lwstall | id_flush_branch;

   assign id_ctrl = '{regwrite: id_regwrite, memtoreg: id_memtoreg, memread: id_memread,
                      memwrite: id_memwrite, branch: id_branch, alusrc: id_alusrc,
                      regdst: id_regdst, aluop: id_aluop};

   // Data fields load even on a bubble; only control, valid and specifiers are squashed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_ctrl            <= CTRL_NOP;
         id_ex_valid        <= 1'b0;
         id_ex_rs           <= REG_ZERO;
         id_ex_registerrt   <= REG_ZERO;
         id_ex_rd           <= REG_ZERO;
         id_ex_pc_plus4     <= '0;
         id_ex_read_data1   <= '0;
         id_ex_read_data2   <= '0;
         id_ex_sign_ext_imm <= '0;
      end else begin
         ex_ctrl            <= bubble ? CTRL_NOP : id_ctrl;
         id_ex_valid        <= id_valid & ~bubble;
         id_ex_rs           <= bubble ? REG_ZERO : id_rs;
         id_ex_registerrt   <= bubble ? REG_ZERO : id_rt;
         id_ex_rd           <= bubble ? REG_ZERO : id_rd;
         id_ex_pc_plus4     <= id_pc_plus4;
         id_ex_read_data1   <= id_read_data1;
         id_ex_read_data2   <= id_read_data2;
         id_ex_sign_ext_imm <= id_sign_ext_imm;
      end
   end

   assign id_ex_regwrite = ex_ctrl.regwrite;
   assign id_ex_memtoreg = ex_ctrl.memtoreg;
   assign id_ex_memread  = ex_ctrl.memread;
   assign id_ex_memwrite = ex_ctrl.memwrite;
   assign id_ex_branch   = ex_ctrl.branch;
   assign id_ex_alusrc   = ex_ctrl.alusrc;
   assign id_ex_regdst   = ex_ctrl.regdst;
   assign id_ex_aluop    = ex_ctrl.aluop;

   sat_counter #(.WIDTH(CNT_W)) u_lwstall_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (1'b0),
      .inc   (id_flush_lwstall),
      .count (lwstall_count)
   );

   sat_counter #(.WIDTH(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (1'b0),
      .inc   (bubble),
      .count (bubble_count)
   );

   sat_counter #(.WIDTH(RUN_W), .MAX(RUN_W'(MAX_LWSTALL + 1))) u_run_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (~id_flush_lwstall),
      .inc   (id_flush_lwstall),
      .count (run_count)
   );

   // Fires on the edge that would push the consecutive-stall run past its limit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         lwstall_timeout <= 1'b0;
      else if (id_flush_lwstall && (run_count == RUN_W'(MAX_LWSTALL)))
         lwstall_timeout <= 1'b1;
   end

endmodule
